// File: rtl/riscv_ppreg_skid.sv
// Generic inter-stage pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Optional stall counter is enabled by defining RISCV_PPREG_STALL_CNT_EN.
module riscv_ppreg_skid #(
    parameter int DATA_W = 256,
    parameter int CTRL_W = 24,
    parameter int CNT_W  = 32
) (
    input  logic              i_riscv_ppreg_clk,
    input  logic              i_riscv_ppreg_rst_n,
    input  logic              i_riscv_ppreg_flush,
    input  logic              i_riscv_ppreg_valid_in,
    output logic              o_riscv_ppreg_ready_in,
    input  logic [DATA_W-1:0] i_riscv_ppreg_data_in,
    input  logic [CTRL_W-1:0] i_riscv_ppreg_ctrl_in,
    output logic              o_riscv_ppreg_valid_out,
    input  logic              i_riscv_ppreg_ready_out,
    output logic [DATA_W-1:0] o_riscv_ppreg_data_out,
    output logic [CTRL_W-1:0] o_riscv_ppreg_ctrl_out,
    output logic [CNT_W-1:0]  o_riscv_ppreg_stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_reg, state_next;

    logic               main_valid_reg, main_valid_next;
    logic [DATA_W-1:0]  main_data_reg,  main_data_next;
    logic [CTRL_W-1:0]  main_ctrl_reg,  main_ctrl_next;

    logic               skid_valid_reg, skid_valid_next;
    logic [DATA_W-1:0]  skid_data_reg,  skid_data_next;
    logic [CTRL_W-1:0]  skid_ctrl_reg,  skid_ctrl_next;

    logic               ready_in_reg,   ready_in_next;

    logic               in_fire;
    logic               out_fire;

    assign in_fire  = i_riscv_ppreg_valid_in & ready_in_reg;
    assign out_fire = main_valid_reg & i_riscv_ppreg_ready_out;

    always_ff @(posedge i_riscv_ppreg_clk or negedge i_riscv_ppreg_rst_n) begin
        if (!i_riscv_ppreg_rst_n) begin
            state_reg      <= ST_EMPTY;
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            main_ctrl_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_ctrl_reg  <= '0;
            ready_in_reg   <= 1'b1;
        end else begin
            state_reg      <= state_next;
            main_valid_reg <= main_valid_next;
            main_data_reg  <= main_data_next;
            main_ctrl_reg  <= main_ctrl_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_ctrl_reg  <= skid_ctrl_next;
            ready_in_reg   <= ready_in_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        main_ctrl_next  = main_ctrl_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_ctrl_next  = skid_ctrl_reg;

        if (i_riscv_ppreg_flush) begin
            state_next      = ST_EMPTY;
            main_valid_next = 1'b0;
            main_data_next  = '0;
            main_ctrl_next  = '0;
            skid_valid_next = 1'b0;
            skid_data_next  = '0;
            skid_ctrl_next  = '0;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_next      = ST_ONE;
                        main_valid_next = 1'b1;
                        main_data_next  = i_riscv_ppreg_data_in;
                        main_ctrl_next  = i_riscv_ppreg_ctrl_in;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_next  = i_riscv_ppreg_data_in;
                        main_ctrl_next  = i_riscv_ppreg_ctrl_in;
                    end else if (out_fire) begin
                        // Data and ctrl stay in the flop; ctrl is masked on the output.
                        state_next      = ST_EMPTY;
                        main_valid_next = 1'b0;
                    end else if (in_fire) begin
                        state_next      = ST_FULL;
                        skid_valid_next = 1'b1;
                        skid_data_next  = i_riscv_ppreg_data_in;
                        skid_ctrl_next  = i_riscv_ppreg_ctrl_in;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_next      = ST_ONE;
                        main_valid_next = 1'b1;
                        main_data_next  = skid_data_reg;
                        main_ctrl_next  = skid_ctrl_reg;
                        skid_valid_next = 1'b0;
                    end
                end
                default: begin
                    state_next      = ST_EMPTY;
                    main_valid_next = 1'b0;
                    skid_valid_next = 1'b0;
                end
            endcase
        end

        // Computed from next skid state so ready_in is a pure flop output.
        ready_in_next = ~skid_valid_next;
    end

    assign o_riscv_ppreg_ready_in  = ready_in_reg;
    assign o_riscv_ppreg_valid_out = main_valid_reg;
    assign o_riscv_ppreg_data_out  = main_data_reg;

    generate
        for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
            assign o_riscv_ppreg_ctrl_out[gi] = main_ctrl_reg[gi] & main_valid_reg;
        end
    endgenerate

`ifdef RISCV_PPREG_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;

    // Saturating count of cycles where an entry waits on downstream; flush does not clear it.
    always_ff @(posedge i_riscv_ppreg_clk or negedge i_riscv_ppreg_rst_n) begin
        if (!i_riscv_ppreg_rst_n) begin
            stall_cnt_reg <= '0;
        end else if (main_valid_reg && !i_riscv_ppreg_ready_out && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_riscv_ppreg_stall_cnt = stall_cnt_reg;
`else
    assign o_riscv_ppreg_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_ppreg_skid.sv
// Bench for riscv_ppreg_skid: directed + random stimulus checked against a queue-based model.
module tb_riscv_ppreg_skid;

    localparam int DW = 256;
    localparam int CW = 24;
    localparam int NW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          valid_in;
    logic          ready_in;
    logic [DW-1:0] data_in;
    logic [CW-1:0] ctrl_in;
    logic          valid_out;
    logic          ready_out;
    logic [DW-1:0] data_out;
    logic [CW-1:0] ctrl_out;
    logic [NW-1:0] stall_cnt;

    riscv_ppreg_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .i_riscv_ppreg_clk       (clk),
        .i_riscv_ppreg_rst_n     (rst_n),
        .i_riscv_ppreg_flush     (flush),
        .i_riscv_ppreg_valid_in  (valid_in),
        .o_riscv_ppreg_ready_in  (ready_in),
        .i_riscv_ppreg_data_in   (data_in),
        .i_riscv_ppreg_ctrl_in   (ctrl_in),
        .o_riscv_ppreg_valid_out (valid_out),
        .i_riscv_ppreg_ready_out (ready_out),
        .o_riscv_ppreg_data_out  (data_out),
        .o_riscv_ppreg_ctrl_out  (ctrl_out),
        .o_riscv_ppreg_stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    // Model: entries in flight in FIFO order, plus the last data word left on the output.
    ent_t            q[$];
    logic [DW-1:0]   hold_d;
    longint unsigned m_cnt;
    int              vectors = 0;
    int              errs = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [NW-1:0] exp_cnt();
`ifdef RISCV_PPREG_STALL_CNT_EN
        return NW'(m_cnt);
`else
        return '0;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        hold_d = '0;
        m_cnt  = 0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        bit in_f, out_f, stl;
        ed = hold_d;
        ec = '0;
        if (q.size() > 0) begin
            ed = q[0].d;
            ec = q[0].c;
        end
        chk("valid_out", DW'(valid_out), DW'(q.size() > 0));
        chk("ready_in",  DW'(ready_in),  DW'(q.size() < 2));
        chk("data_out",  data_out,       ed);
        chk("ctrl_out",  DW'(ctrl_out),  DW'(ec));
        chk("stall_cnt", DW'(stall_cnt), DW'(exp_cnt()));
        in_f  = valid_in && (q.size() < 2);
        out_f = (q.size() > 0) && ready_out;
        stl   = (q.size() > 0) && !ready_out;
        @(posedge clk);
        if (stl && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (flush) begin
            q.delete();
            hold_d = '0;
        end else begin
            if (out_f) begin
                hold_d = q[0].d;
                void'(q.pop_front());
            end
            if (in_f) q.push_back('{d: data_in, c: ctrl_in});
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c);
        valid_in = v;
        data_in  = d;
        ctrl_in  = c;
    endtask

    task automatic async_reset();
        valid_in = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("async_valid_out", DW'(valid_out), DW'(0));
        chk("async_ready_in",  DW'(ready_in),  DW'(1));
        chk("async_ctrl_out",  DW'(ctrl_out),  DW'(0));
        chk("async_stall_cnt", DW'(stall_cnt), DW'(0));
        #2;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        ready_out = 1'b1;
        drive(1'b0, '0, '0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state, then a single entry.
        tick();
        drive(1'b1, DW'(64'h1234_5678_9ABC_DEF0), 24'hA5A5A5);
        tick();
        drive(1'b0, rand_data(), 24'h5A5A5A);
        repeat (2) tick();

        // Backpressure into the skid buffer, then drain.
        ready_out = 1'b0;
        drive(1'b1, DW'(1), 24'h000011);
        tick();
        drive(1'b1, DW'(2), 24'h000022);
        tick();
        drive(1'b0, DW'(3), '0);
        tick();
        ready_out = 1'b1;
        repeat (3) tick();

        // Streaming at full throughput.
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, DW'(i), CW'($urandom));
            tick();
        end
        drive(1'b0, '0, '0);
        repeat (2) tick();

        // Flush while FULL; the flush-cycle input must be dropped.
        ready_out = 1'b0;
        drive(1'b1, DW'(10), 24'h0000AA);
        tick();
        drive(1'b1, DW'(11), 24'h0000BB);
        tick();
        flush = 1'b1;
        drive(1'b1, DW'(16'hDEAD), 24'hFFFFFF);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        ready_out = 1'b1;
        repeat (3) tick();

        // Long flush with live traffic, then resume.
        flush = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, rand_data(), CW'($urandom));
            ready_out = 1'($urandom_range(0, 1));
            tick();
        end
        flush = 1'b0;
        ready_out = 1'b1;
        drive(1'b1, DW'(64'hCAFE), 24'h123456);
        tick();
        drive(1'b0, '0, '0);
        repeat (2) tick();

        // Asynchronous reset while FULL.
        ready_out = 1'b0;
        drive(1'b1, rand_data(), CW'($urandom));
        tick();
        drive(1'b1, rand_data(), CW'($urandom));
        tick();
        async_reset();
        tick();

        // Seven stalled cycles after reset.
        drive(1'b1, DW'(77), 24'h777777);
        tick();
        drive(1'b0, '0, '0);
        repeat (7) tick();
        chk("stall_after_7", DW'(stall_cnt), DW'(exp_cnt()));
`ifdef RISCV_PPREG_STALL_CNT_EN
        chk("stall_is_7", DW'(stall_cnt), DW'(7));
`endif
        async_reset();
        ready_out = 1'b1;
        tick();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), rand_data(), CW'($urandom));
            ready_out = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0;
        drive(1'b0, '0, '0);
        ready_out = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/riscv_ppreg_skid.md
Name: riscv_ppreg_skid

Overview:
- Parametrised successor to the fixed decode/execute pipeline register. One generic inter-stage register usable at every pipeline boundary (FD, DE, EM, MW).
- Adds a valid/ready handshake with a 2-entry skid buffer, giving full throughput with registered backpressure.
- Adds a synchronous flush that squashes all in-flight entries.
- Payload is split into two fields:
  - CTRL: control bits, forced to zero when the output is not valid.
  - DATA: datapath bits, PC/operands/immediates.

Parameters:
- DATA_W, 256: width of the datapath payload field.
- CTRL_W, 24: width of the control field (regwrite, memwrite, resultsrc, alucontrol, ...).
- CNT_W, 32: width of the stall counter (optional feature only).

Ports:
- i_riscv_ppreg_clk  in  1  clock, rising edge.
- i_riscv_ppreg_rst_n  in  1  asynchronous, active-low reset.
- i_riscv_ppreg_flush  in  1  synchronous squash of all entries.
- i_riscv_ppreg_valid_in  in  1  upstream entry valid.
- o_riscv_ppreg_ready_in  out  1  this block can accept an entry.
- i_riscv_ppreg_data_in  in  DATA_W  upstream datapath payload.
- i_riscv_ppreg_ctrl_in  in  CTRL_W  upstream control payload.
- o_riscv_ppreg_valid_out  out  1  output entry valid.
- i_riscv_ppreg_ready_out  in  1  downstream accepts; 0 = stall.
- o_riscv_ppreg_data_out  out  DATA_W  output datapath payload.
- o_riscv_ppreg_ctrl_out  out  CTRL_W  output control payload; 0 when valid_out=0.
- o_riscv_ppreg_stall_cnt  out  CNT_W  stall cycle count (see Optional Feature).

Behaviour:
- Clock and reset: single clock i_riscv_ppreg_clk. Reset i_riscv_ppreg_rst_n is asynchronous, active-low.
- Reset values: state EMPTY; main and skid entries cleared; valid_out=0, data_out=0, ctrl_out=0, ready_in=1, stall_cnt=0.
- Reset mid-operation: all entries are lost immediately, with no pending handshake.
- Storage: main register (drives the outputs) and skid register, each holding {valid, data, ctrl}.
- Handshakes: in_fire = valid_in & ready_in; out_fire = valid_out & ready_out.
- ready_in = !skid.valid. It is a registered flop, with no combinational path from ready_out.
- valid_out = main.valid; data_out = main.data; ctrl_out = main.ctrl & {CTRL_W{main.valid}}.
- Latency: 1 cycle, input edge to output. Throughput: 1 entry/cycle while ready_out=1.
- State transitions (no flush):
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE: in_fire & out_fire -> ONE, main<=in.
  - ONE: out_fire only -> EMPTY, main.valid<=0, data held.
  - ONE: in_fire only -> FULL, skid<=in.
  - FULL: ready_in=0; out_fire -> ONE, main<=skid, skid.valid<=0.
  - FULL: no out_fire -> hold.
- Flush (highest priority below reset): at the next edge, main and skid are cleared to all zeros (valid, data and ctrl); state becomes EMPTY.
  - An input presented in the flush cycle is dropped.
  - An output accepted in the flush cycle counts as delivered; downstream owns its own squash.
- Flush held high for N cycles: outputs remain zero and ready_in=1 throughout; valid_in is ignored.
- Ordering: strict FIFO order is preserved; an entry is never duplicated or dropped except by flush.
- Payload changes on data_in while valid_in=0 have no effect.

Optional Feature:
- Macro: RISCV_PPREG_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on every cycle with valid_out=1 and ready_out=0.
  - It saturates at 2^CNT_W-1.
  - It is cleared only by reset; flush does not clear it.
- Undefined: no counter logic is generated; stall_cnt is tied to 0.

Test Plan:
- Reset then single entry: release rst_n; data_in=64'h123456789ABCDEF0 (zero-extended to DATA_W), ctrl_in=24'hA5A5A5, valid_in=1 for 1 cycle, ready_out=1.
  -> Next cycle valid_out=1 with the same data and ctrl; the cycle after, valid_out=0 and ctrl_out=0.
- Backpressure and skid: ready_out=0; send entries D0=1, D1=2.
  -> After D1, ready_in=0 and valid_out=1 with data_out=1.
  -> Raise ready_out; outputs 1 then 2 on consecutive cycles; ready_in returns to 1 one cycle after the first out_fire.
- Streaming: 100 back-to-back entries (data=index) with ready_out=1.
  -> 100 consecutive valid_out cycles, data 0..99 in order, ready_in always 1.
- Flush when FULL: fill both entries, assert flush for 1 cycle with valid_in=1 and data=0xDEAD.
  -> Next cycle valid_out=0, data_out=0, ctrl_out=0, ready_in=1; 0xDEAD never appears.
- Long flush then resume: flush high for 10 cycles while driving valid entries.
  -> Outputs stay zero throughout.
  -> After deassertion, the first entry appears 1 cycle after acceptance.
- Async reset mid-stream: pulse rst_n low for 3 ns between edges while FULL.
  -> valid_out=0 and ready_in=1 immediately, without waiting for an edge.
  -> With RISCV_PPREG_STALL_CNT_EN: hold ready_out=0 with valid_out=1 for 7 cycles -> stall_cnt=7; then reset -> stall_cnt=0.
